// File: rtl/conv_pkg.sv
// Shared types for the 5x5 convolution front end: pixel and window types
// used by conv_window_gen and the downstream convolution pipeline.
package conv_pkg;

    localparam int K      = 5;
    localparam int DATA_W = 8;

    typedef logic signed [DATA_W-1:0] pix_t;
    typedef pix_t [K-1:0][K-1:0]      window_t;

    // Saturating 16-bit increment used by the optional window counter
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        logic [15:0] r;
        if (v == 16'hFFFF) begin
            r = v;
        end else begin
            r = v + 16'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// Single image-row delay line: a circular buffer of DEPTH pixels that only
// advances when en is high. dout is the pixel written DEPTH enables ago.
module conv_line_buffer
    import conv_pkg::*;
#(
    parameter int DEPTH = 32
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  pix_t din,
    output pix_t dout
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

    pix_t             mem [DEPTH];
    logic [PTR_W-1:0] ptr_r;

    // Read-before-write: the slot about to be overwritten holds the oldest pixel
    assign dout = mem[ptr_r];

    // Advance the circular pointer on every enabled cycle, restart on reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_r <= '0;
        end else if (en) begin
            if (ptr_r == PTR_LAST) begin
                ptr_r <= '0;
            end else begin
                ptr_r <= ptr_r + PTR_W'(1);
            end
        end
    end

    // Storage is not reset; stale contents never reach a valid window
    always_ff @(posedge clk) begin
        if (en) begin
            mem[ptr_r] <= din;
        end
    end

endmodule

// File: rtl/conv_window_gen.sv
// Streaming KxK sliding-window generator (no padding). Four line buffers hold
// the previous rows; a KxK register array shifts left on each accepted pixel.
// Optional feature: define WINGEN_WIN_COUNT_EN to add the win_count output
// (windows handed off in the current frame, saturating at 16'hFFFF).
module conv_window_gen
    import conv_pkg::*;
#(
    parameter int IMG_W = 32,
    parameter int IMG_H = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     pix_valid,
    output logic                     pix_ready,
    input  logic signed [DATA_W-1:0] pix_data,
    output logic                     win_valid,
    input  logic                     win_ready,
    output window_t                  window,
    output logic                     win_last,
    output logic                     frame_done
`ifdef WINGEN_WIN_COUNT_EN
    ,
    output logic [15:0]              win_count
`endif
);

    localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
    localparam logic [COL_W-1:0] COL_MIN  = COL_W'(K - 1);
    localparam logic [ROW_W-1:0] ROW_MIN  = ROW_W'(K - 1);

    logic [COL_W-1:0] col_r;
    logic [ROW_W-1:0] row_r;
    logic             accept;
    logic             col_end;
    logic             frame_end;
    logic             win_ok;
    pix_t             lb_in  [K-1];
    pix_t             lb_out [K-1];
    pix_t             new_col [K];

    // No input-side buffering: a pending window blocks new pixels until taken
    assign pix_ready = !win_valid || win_ready;
    assign accept    = pix_valid && pix_ready;
    assign col_end   = (col_r == COL_LAST);
    assign frame_end = col_end && (row_r == ROW_LAST);
    assign win_ok    = (row_r >= ROW_MIN) && (col_r >= COL_MIN);

    // Chain the line buffers and build the incoming column, oldest row first
    always_comb begin
        lb_in[0]   = pix_data;
        new_col[K-1] = pix_data;
        for (int i = 1; i < K-1; i++) begin
            lb_in[i] = lb_out[i-1];
        end
        for (int r = 0; r < K-1; r++) begin
            new_col[r] = lb_out[K-2-r];
        end
    end

    for (genvar i = 0; i < K-1; i++) begin : g_lb
        conv_line_buffer #(
            .DEPTH (IMG_W)
        ) u_lb (
            .clk   (clk),
            .rst_n (rst_n),
            .en    (accept),
            .din   (lb_in[i]),
            .dout  (lb_out[i])
        );
    end

    // Shift the window left and load the new column on every accepted pixel
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K-1; c++) begin
                    window[r][c] <= window[r][c+1];
                end
                window[r][K-1] <= new_col[r];
            end
        end
    end

    // Raster position, output valid/last flags and end-of-frame pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_r      <= '0;
            row_r      <= '0;
            win_valid  <= 1'b0;
            win_last   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= accept && frame_end;
            if (accept) begin
                win_valid <= win_ok;
                win_last  <= frame_end;
                if (col_end) begin
                    col_r <= '0;
                    if (row_r == ROW_LAST) begin
                        row_r <= '0;
                    end else begin
                        row_r <= row_r + ROW_W'(1);
                    end
                end else begin
                    col_r <= col_r + COL_W'(1);
                end
            end else if (win_ready) begin
                win_valid <= 1'b0;
                win_last  <= 1'b0;
            end
        end
    end

`ifdef WINGEN_WIN_COUNT_EN
    logic handoff;
    logic count_clear_r;

    assign handoff = win_valid && win_ready;

    // Count handed-off windows; the final count is visible for one cycle
    // after the last window of the frame leaves, then returns to zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_count     <= 16'd0;
            count_clear_r <= 1'b0;
        end else begin
            count_clear_r <= handoff && win_last;
            if (count_clear_r) begin
                win_count <= handoff ? 16'd1 : 16'd0;
            end else if (handoff) begin
                win_count <= sat_inc16(win_count);
            end
        end
    end
`endif

endmodule
